// File: rtl/ntt_ctrl_if.sv
// ntt_ctrl_if: handshake and memory-bus bundle between the NTT sequencer and
// its surroundings (coefficient RAM, twiddle ROM, butterfly unit).
// master = the controller side, slave = the consumer/driver side.
interface ntt_ctrl_if;
  logic       start;
  logic       mode;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic [6:0] tw_addr;
  logic       sel_out;
  logic       wr_en;
  logic [7:0] wr_addr_a;
  logic [7:0] wr_addr_b;

  modport master (
    input  start, mode,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           sel_out, wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start, mode,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           sel_out, wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: sequencer for the 256-point ML-KEM NTT butterfly datapath.
// Walks 7 Cooley-Tukey layers, one butterfly per cycle, issuing operand and
// twiddle addresses, then drains RD_LAT+BU_LAT cycles between layers.
// Write strobes/addresses are the read strobes/addresses delayed by
// RD_LAT+BU_LAT cycles.
// Optional macro NTT_CTRL_INTT_EN: adds inverse-NTT ordering selected by mode=1.
module ntt_ctrl #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BU_LAT = 3
) (
  input logic        clk,
  input logic        rst_n,
  ntt_ctrl_if.master bus
);

  localparam int unsigned D  = RD_LAT + BU_LAT;
  localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(D - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]    state;
  logic [2:0]    layer;
  logic [6:0]    j;
  logic [CW-1:0] cnt;

  logic          rd_en;
  logic [3:0]    k;
  logic [7:0]    len;
  logic [6:0]    g;
  logic [7:0]    a;
  logic [6:0]    tw;

  logic          wr_pipe [D];
  logic [7:0]    wa_pipe [D];
  logic [7:0]    wb_pipe [D];

`ifdef NTT_CTRL_INTT_EN
  logic          mode_lat;
  logic          sel_pipe [RD_LAT];
`endif

  // Layer/index sequencing: IDLE -> RUN (128 butterflies) -> DRAIN (D cycles) -> ... -> FIN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      layer <= '0;
      j     <= '0;
      cnt   <= '0;
`ifdef NTT_CTRL_INTT_EN
      mode_lat <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_RUN;
            layer <= '0;
            j     <= '0;
`ifdef NTT_CTRL_INTT_EN
            mode_lat <= bus.mode;
`endif
          end
        end
        S_RUN: begin
          j <= j + 7'd1;
          if (j == 7'd127) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            if (layer == 3'd6) begin
              state <= S_FIN;
            end else begin
              layer <= layer + 3'd1;
              j     <= '0;
              state <= S_RUN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Butterfly address generation: k = log2(len), g = j >> k, o = j & (len-1)
  always_comb begin
`ifdef NTT_CTRL_INTT_EN
    if (mode_lat) k = {1'b0, layer} + 4'd1;
    else          k = 4'd7 - {1'b0, layer};
`else
    k = 4'd7 - {1'b0, layer};
`endif
    len = 8'd1 << k;
    g   = j >> k;
    a   = ({1'b0, g} << (k + 4'd1)) + ({1'b0, j} & (len - 8'd1));
`ifdef NTT_CTRL_INTT_EN
    if (mode_lat) tw = (7'd127 >> layer) - g;
    else          tw = (7'd1 << layer) + g;
`else
    tw = (7'd1 << layer) + g;
`endif
  end

  assign rd_en         = (state == S_RUN);
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr_a = rd_en ? a : '0;
  assign bus.rd_addr_b = rd_en ? (a + len) : '0;
  assign bus.tw_addr   = rd_en ? tw : '0;
  assign bus.busy      = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done      = (state == S_FIN);

  // Write-back delay line: read strobe/addresses delayed by D cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < D; i++) begin
        wr_pipe[i] <= 1'b0;
        wa_pipe[i] <= '0;
        wb_pipe[i] <= '0;
      end
    end else begin
      wr_pipe[0] <= rd_en;
      wa_pipe[0] <= bus.rd_addr_a;
      wb_pipe[0] <= bus.rd_addr_b;
      for (int unsigned i = 1; i < D; i++) begin
        wr_pipe[i] <= wr_pipe[i-1];
        wa_pipe[i] <= wa_pipe[i-1];
        wb_pipe[i] <= wb_pipe[i-1];
      end
    end
  end

  assign bus.wr_en     = wr_pipe[D-1];
  assign bus.wr_addr_a = wa_pipe[D-1];
  assign bus.wr_addr_b = wb_pipe[D-1];

`ifdef NTT_CTRL_INTT_EN
  // Mode select travels with the operands so it arrives with the RAM/ROM data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) sel_pipe[i] <= 1'b0;
    end else begin
      sel_pipe[0] <= rd_en & mode_lat;
      for (int unsigned i = 1; i < RD_LAT; i++) sel_pipe[i] <= sel_pipe[i-1];
    end
  end

  assign bus.sel_out = sel_pipe[RD_LAT-1];
`else
  assign bus.sel_out = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: scoreboard bench for ntt_ctrl. Expected reads/writes are queued
// when a transform is started and popped as the DUT emits them.
module tb_ntt_ctrl;

  localparam int RD_LAT = 1;
  localparam int BU_LAT = 3;
  localparam int D      = RD_LAT + BU_LAT;
  localparam int DONE_C = 7 * (128 + D) + 1;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  int   base = 0;
  bit   mon_en = 1'b0;
  bit   intt_run = 1'b0;
  int   done_seen = 0;
  int   wr_count = 0;
  ev_t  rd_q[$];
  ev_t  wr_q[$];

  ntt_ctrl_if bus ();

  ntt_ctrl #(.RD_LAT(RD_LAT), .BU_LAT(BU_LAT)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit is_read_cycle(input int c);
    int off;
    if (c < 1) return 1'b0;
    off = c - 1;
    return ((off / (128 + D)) < 7) && ((off % (128 + D)) < 128);
  endfunction

  // Build the expected read/write streams straight from the layer formulas
  task automatic load_expect(input bit intt);
    ev_t e;
    int len, g, o;
    rd_q.delete();
    wr_q.delete();
    for (int l = 0; l < 7; l++) begin
      len = intt ? (2 << l) : (128 >> l);
      for (int jj = 0; jj < 128; jj++) begin
        g     = jj / len;
        o     = jj % len;
        e.cyc = 1 + l * (128 + D) + jj;
        e.a   = 2 * len * g + o;
        e.b   = e.a + len;
        e.tw  = intt ? (2 * (128 / len) - 1 - g) : (128 / len + g);
        rd_q.push_back(e);
        e.cyc = e.cyc + D;
        e.tw  = 0;
        wr_q.push_back(e);
      end
    end
  endtask

  // Scoreboard monitor, sampling mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      int  cyc;
      ev_t e;
      cyc = edge_cnt - base + 1;
      if (bus.rd_en) begin
        if (rd_q.size() == 0) check("rd_extra", cyc, -1);
        else begin
          e = rd_q.pop_front();
          check("rd_cyc", cyc, e.cyc);
          check("rd_a", bus.rd_addr_a, e.a);
          check("rd_b", bus.rd_addr_b, e.b);
          check("tw", bus.tw_addr, e.tw);
        end
      end
      if (bus.wr_en) begin
        wr_count++;
        if (wr_q.size() == 0) check("wr_extra", cyc, -1);
        else begin
          e = wr_q.pop_front();
          check("wr_cyc", cyc, e.cyc);
          check("wr_a", bus.wr_addr_a, e.a);
          check("wr_b", bus.wr_addr_b, e.b);
        end
      end
      if (bus.done) done_seen++;
      check("done", bus.done, (cyc == DONE_C) ? 1 : 0);
      check("busy", bus.busy, (cyc >= 1 && cyc < DONE_C) ? 1 : 0);
      check("sel", bus.sel_out, (intt_run && is_read_cycle(cyc - RD_LAT)) ? 1 : 0);
    end
  end

  task automatic run_transform(input bit m, input bit poke);
    bit intt;
`ifdef NTT_CTRL_INTT_EN
    intt = m;
`else
    intt = 1'b0;
`endif
    load_expect(intt);
    done_seen = 0;
    wr_count  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    @(posedge clk);
    #1;
    base      = edge_cnt;
    intt_run  = intt;
    mon_en    = 1'b1;
    bus.start = 1'b0;
    for (int n = 0; n < 3000 && done_seen == 0; n++) begin
      @(negedge clk);
      #1;
      if (poke) begin
        bus.start = (n == 300 || n == 661 || n == 700);
        if (n == 400) bus.mode = ~m;
      end
    end
    bus.start = 1'b0;
    check("done_seen", done_seen, 1);
    repeat (3) @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("rd_left", rd_q.size(), 0);
    check("wr_left", wr_q.size(), 0);
    check("wr_total", wr_count, 896);
    check("done_once", done_seen, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.sel_out},  0);
    check({tag, "_addr"}, {bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr,
                           bus.wr_addr_a, bus.wr_addr_b}, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    bus.start = 1'b0;
    rst_n     = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle_rd", bus.rd_en, 0);
      check("idle_busy", bus.busy, 0);
    end

    run_transform(1'b0, 1'b1);

    // Reset in the middle of layer 3
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3 * (128 + D) + 20) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("mid_rst");
    rst_n = 1'b1;
    repeat (D + 4) begin
      @(negedge clk);
      check("post_rst_wr", bus.wr_en, 0);
      check("post_rst_rd", bus.rd_en, 0);
    end

    run_transform(1'b0, 1'b0);
`ifdef NTT_CTRL_INTT_EN
    run_transform(1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
